ac_stream_bridge: RTL and testbench

Parametrised stream bridge between the AXI-Stream ports and the upsampling processing element. It converts input AXI-Stream beats into the N-lane `ac_upsp_r*` read handshake, and buffers the PE's `upsp_ac_w*` results in an output FIFO. It frames the output stream with `tlast` (end of each destination row) and `tuser` (first beat of a frame), counts input handshakes, and signals frame completion. It generalises the fixed-width, single-mode access path to configurable channel count, lane count, image size and FIFO depth, and adds abort support.

---
 rtl/ac_pkg.sv | 40 ++++
 rtl/ac_sync_fifo.sv | 47 ++++
 rtl/ac_stream_bridge.sv | 141 ++++++++++++++
 tb/tb_ac_stream_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// Shared types and parameter-derivation helpers for the AXI-Stream <-> upsampler bridge.
package ac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ac_state_e;

  function automatic int calc_pixel_w(input int cw, input int nch);
    return cw * nch;
  endfunction

  function automatic int calc_data_w(input int cw, input int nch, input int np);
    return np * calc_pixel_w(cw, nch);
  endfunction

  function automatic int calc_in_beats(input int sw, input int sh, input int np);
    return (sw * sh) / np;
  endfunction

  function automatic int calc_row_beats(input int dw, input int np);
    return dw / np;
  endfunction

  function automatic int calc_out_beats(input int dw, input int dh, input int np);
    return calc_row_beats(dw, np) * dh;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Configuration legality, evaluated at elaboration by the top.
  function automatic bit cfg_ok(input int sw, input int dw, input int np, input int depth);
    return (np > 0) && (sw % np == 0) && (dw % np == 0) && is_pow2(depth);
  endfunction

endpackage

// File: rtl/ac_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous flush.
module ac_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr, rd;

  assign wr = wr_en_i && !full_o;
  assign rd = rd_en_i && !empty_o;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Head is masked so the output reads zero while nothing is queued.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ac_stream_bridge.sv
// Bridges AXI-Stream in/out to the upsampling PE read/write handshakes with frame
// accounting, tlast/tuser framing and abort.
module ac_stream_bridge
  import ac_pkg::*;
#(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int N_CHANNEL      = 3,
  parameter int N_PARALLEL     = 2,
  parameter int SRC_IMG_WIDTH  = 960,
  parameter int SRC_IMG_HEIGHT = 540,
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160,
  parameter int OUT_FIFO_DEPTH = 16,
  parameter int CRF_DATA_WIDTH = 32,
  localparam int DATA_W = calc_data_w(CHANNEL_WIDTH, N_CHANNEL, N_PARALLEL)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [CRF_DATA_WIDTH-1:0] in_hsk_cnt,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_W-1:0]         s_axis_tdata,
  output logic                      ac_upsp_rvalid,
  input  logic                      upsp_ac_rready,
  output logic [DATA_W-1:0]         ac_upsp_rdata,
  input  logic                      upsp_ac_wvalid,
  output logic                      ac_upsp_wready,
  input  logic [DATA_W-1:0]         upsp_ac_wdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser
);

  localparam int IN_BEATS  = calc_in_beats(SRC_IMG_WIDTH, SRC_IMG_HEIGHT, N_PARALLEL);
  localparam int ROW_BEATS = calc_row_beats(DST_IMG_WIDTH, N_PARALLEL);
  localparam int OUT_BEATS = calc_out_beats(DST_IMG_WIDTH, DST_IMG_HEIGHT, N_PARALLEL);
  localparam int COL_W     = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam int ROW_W     = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;

  localparam logic [CRF_DATA_WIDTH-1:0] IN_BEATS_C = CRF_DATA_WIDTH'(IN_BEATS);
  localparam logic [COL_W-1:0]          COL_LAST   = COL_W'(ROW_BEATS - 1);
  localparam logic [ROW_W-1:0]          ROW_LAST   = ROW_W'(DST_IMG_HEIGHT - 1);

  if (!cfg_ok(SRC_IMG_WIDTH, DST_IMG_WIDTH, N_PARALLEL, OUT_FIFO_DEPTH) || OUT_BEATS < 1 || IN_BEATS < 1)
  begin : g_cfg_err
    $error("ac_stream_bridge: illegal parameter combination");
  end

  ac_state_e                 state_q;
  logic [CRF_DATA_WIDTH-1:0] cnt_q;
  logic                      rvalid_q;
  logic [DATA_W-1:0]         rdata_q;
  logic [COL_W-1:0]          col_q;
  logic [ROW_W-1:0]          row_q;

  logic abort_evt, in_hsk, push, pop, last_out;
  logic fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  assign abort_evt = abort && (state_q != IDLE);
  assign in_hsk    = s_axis_tvalid && s_axis_tready;
  assign push      = upsp_ac_wvalid && ac_upsp_wready;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign last_out  = pop && (col_q == COL_LAST) && (row_q == ROW_LAST);

  assign s_axis_tready  = (state_q == RUN) && (cnt_q < IN_BEATS_C) && (!rvalid_q || upsp_ac_rready);
  assign ac_upsp_wready = ((state_q == RUN) || (state_q == DRAIN)) && !fifo_full;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign in_hsk_cnt     = cnt_q;
  assign ac_upsp_rvalid = rvalid_q;
  assign ac_upsp_rdata  = rdata_q;
  assign m_axis_tvalid  = !fifo_empty;
  assign m_axis_tdata   = fifo_dout;
  assign m_axis_tlast   = !fifo_empty && (col_q == COL_LAST);
  assign m_axis_tuser   = !fifo_empty && (col_q == '0) && (row_q == '0);

  // Reset and abort share one flush path; abort outranks every other event.
  always_ff @(posedge clk) begin
    if (!rst_n || abort_evt) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN: begin
          if (last_out)                              state_q <= DONE;
          else if (cnt_q == IN_BEATS_C && !rvalid_q) state_q <= DRAIN;
        end
        DRAIN:   if (last_out) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (state_q == IDLE && start) cnt_q <= '0;
      else if (in_hsk)              cnt_q <= cnt_q + CRF_DATA_WIDTH'(1);

      if (in_hsk) begin
        rvalid_q <= 1'b1;
        rdata_q  <= s_axis_tdata;
      end else if (upsp_ac_rready) begin
        rvalid_q <= 1'b0;
      end

      if (pop) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  ac_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (abort_evt),
    .wr_en_i   (push),
    .wr_data_i (upsp_ac_wdata),
    .rd_en_i   (m_axis_tready),
    .rd_data_o (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_ac_stream_bridge.sv
// Directed bench: SRC 4x2, DST 16x8, two lanes, 4-deep output FIFO.
module tb_ac_stream_bridge;

  localparam int DW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, busy, done;
  logic [31:0]   in_hsk_cnt;
  logic          s_tvalid, s_tready, rvalid, rready, wvalid, wready, m_tvalid, m_tready, tlast, tuser;
  logic [DW-1:0] s_tdata, rdata, wdata, m_tdata;

  int n_tests = 0;
  int n_fail  = 0;
  int pi, po;

  ac_stream_bridge #(
    .CHANNEL_WIDTH (8), .N_CHANNEL (3), .N_PARALLEL (2),
    .SRC_IMG_WIDTH (4), .SRC_IMG_HEIGHT (2),
    .DST_IMG_WIDTH (16), .DST_IMG_HEIGHT (8),
    .OUT_FIFO_DEPTH (4), .CRF_DATA_WIDTH (32)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .busy (busy), .done (done), .in_hsk_cnt (in_hsk_cnt),
    .s_axis_tvalid (s_tvalid), .s_axis_tready (s_tready), .s_axis_tdata (s_tdata),
    .ac_upsp_rvalid (rvalid), .upsp_ac_rready (rready), .ac_upsp_rdata (rdata),
    .upsp_ac_wvalid (wvalid), .ac_upsp_wready (wready), .upsp_ac_wdata (wdata),
    .m_axis_tvalid (m_tvalid), .m_axis_tready (m_tready), .m_axis_tdata (m_tdata),
    .m_axis_tlast (tlast), .m_axis_tuser (tuser)
  );

  function automatic logic [DW-1:0] pat(input int k);
    logic [23:0] v;
    v = k[23:0];
    return {v, v};
  endfunction

  function automatic logic [DW-1:0] res(input int j);
    logic [23:0] v;
    v = j[23:0];
    return {v ^ 24'hC0FFEE, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_in(input int k);
    s_tvalid = 1'b1;
    s_tdata  = pat(k);
    #1;
    chk("in_tready", s_tready, 1);
    tick();
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, pat(k));
    chk("in_cnt", in_hsk_cnt, k);
  endtask

  // Acts as PE (pushes results pi..pmax) and sink (pops until beat qmax), tready held high.
  task automatic stream(input int pmax, input int qmax);
    int cyc;
    cyc = 0;
    while (po <= qmax && cyc < 400) begin
      bit pu, pp;
      wvalid   = (pi <= pmax);
      wdata    = res(pi);
      m_tready = 1'b1;
      #1;
      pu = wvalid && wready;
      pp = m_tvalid;
      if (pp) begin
        chk("tdata", m_tdata, res(po));
        chk("tlast", tlast, (po % 8 == 0));
        chk("tuser", tuser, (po == 1));
      end
      chk("done_early", done, 0);
      tick();
      if (pu) pi++;
      if (pp) po++;
      cyc++;
    end
    wvalid   = 1'b0;
    m_tready = 1'b0;
    chk("stream_timeout", (po > qmax), 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; rready = 1'b1;
    wvalid = 1'b0; wdata = '0; m_tready = 1'b0;
    tick(); tick(); tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_mtvalid", m_tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_cnt", in_hsk_cnt, 0);
    chk("rst_mtdata", m_tdata, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Frame 1: full frame with start-while-busy and input over-supply.
    start = 1'b1; tick(); start = 1'b0;
    chk("f1_busy", busy, 1);
    send_in(1);
    send_in(2);
    start = 1'b1;
    send_in(3);
    start = 1'b0;
    chk("startbusy_busy", busy, 1);
    send_in(4);
    s_tvalid = 1'b1; s_tdata = pat(5);
    #1;
    chk("oversupply_tready", s_tready, 0);
    tick();
    chk("oversupply_cnt", in_hsk_cnt, 4);
    chk("slice_empty", rvalid, 0);
    s_tvalid = 1'b0;
    pi = 1; po = 1;
    stream(64, 64);
    chk("f1_done", done, 1);
    chk("f1_busy_in_done", busy, 1);
    chk("f1_fifo_empty", m_tvalid, 0);
    tick();
    chk("f1_done_fall", done, 0);
    chk("f1_busy_fall", busy, 0);
    chk("f1_wready_idle", wready, 0);
    chk("f1_cnt_end", in_hsk_cnt, 4);

    // Frame 2: back-pressure then abort after 20 output beats.
    start = 1'b1; tick(); start = 1'b0;
    send_in(1);
    send_in(2);
    s_tvalid = 1'b0;
    pi = 1; po = 1;
    for (int i = 0; i < 6; i++) begin
      bit pu;
      wvalid = 1'b1; wdata = res(pi); m_tready = 1'b0;
      #1;
      chk("bp_wready", wready, (i < 4));
      if (i >= 1) begin
        chk("bp_tvalid", m_tvalid, 1);
        chk("bp_tdata_stable", m_tdata, res(1));
        chk("bp_tuser_stable", tuser, 1);
      end
      pu = wready;
      tick();
      if (pu) pi++;
    end
    chk("bp_accepted", pi, 5);
    stream(22, 20);
    chk("pre_abort_tvalid", m_tvalid, 1);
    chk("pre_abort_cnt", in_hsk_cnt, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_tvalid", m_tvalid, 0);
    chk("abort_cnt", in_hsk_cnt, 0);
    chk("abort_done", done, 0);
    chk("abort_tuser", tuser, 0);
    chk("abort_wready", wready, 0);
    tick();
    chk("abort_no_done", done, 0);

    // Frame 3: fresh start frames beat 1 with tuser, then reset in DRAIN.
    start = 1'b1; tick(); start = 1'b0;
    pi = 1; po = 1;
    stream(1, 1);
    send_in(1);
    send_in(2);
    send_in(3);
    send_in(4);
    s_tvalid = 1'b0;
    tick(); tick(); tick();
    chk("drain_busy", busy, 1);
    chk("drain_tready", s_tready, 0);
    chk("drain_wready", wready, 1);
    wvalid = 1'b1; wdata = res(2); tick();
    wdata = res(3); tick();
    wvalid = 1'b0;
    #1;
    chk("drain_tvalid", m_tvalid, 1);
    chk("drain_tdata", m_tdata, res(2));
    chk("drain_tuser", tuser, 0);
    rst_n = 1'b0; tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_tvalid", m_tvalid, 0);
    chk("mrst_tdata", m_tdata, 0);
    chk("mrst_tlast", tlast, 0);
    chk("mrst_tuser", tuser, 0);
    chk("mrst_cnt", in_hsk_cnt, 0);
    chk("mrst_tready", s_tready, 0);
    chk("mrst_rvalid", rvalid, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_wready", wready, 0);
    rst_n = 1'b1; tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tvalid", m_tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
